// File: rtl/encoder_8to3_scan.sv
// rtl/encoder_8to3_scan.sv - sequential 8-to-3 encoder emitting one index per set bit
module encoder_8to3_scan #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [2:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       dout_last,
    output logic       busy,
    output logic       zero_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [2:0] dout_q, dout_d;
    logic       dout_valid_q, dout_valid_d;
    logic       dout_last_q, dout_last_d;
    logic       zero_err_q, zero_err_d;

    // Index of the bit emitted next: lowest set bit or highest set bit.
    function automatic logic [2:0] pick_index(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        if (LSB_FIRST) begin
            for (int i = 7; i >= 0; i--) begin
                if (vec[i]) idx = i[2:0];
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (vec[i]) idx = i[2:0];
            end
        end
        return idx;
    endfunction

    // True when exactly one bit of vec is set.
    function automatic logic is_single(input logic [7:0] vec);
        return (vec != 8'h00) && ((vec & (vec - 8'd1)) == 8'h00);
    endfunction

    // Next state, next pending set and the output values they imply.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        zero_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (din_valid) begin
                    if (din != 8'h00) begin
                        pending_d = din;
                        state_d   = S_EMIT;
                    end else begin
                        zero_err_d = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (dout_ready) begin
                    pending_d = pending_q & ~(8'b1 << dout_q);
                    if (dout_last_q) state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                pending_d = 8'h00;
            end
        endcase
        dout_valid_d = (state_d == S_EMIT);
        dout_d       = dout_valid_d ? pick_index(pending_d) : 3'd0;
        dout_last_d  = dout_valid_d && is_single(pending_d);
    end

    // State, pending set and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pending_q    <= 8'h00;
            dout_q       <= 3'd0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            zero_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            zero_err_q   <= zero_err_d;
        end
    end

    assign din_ready  = (state_q == S_IDLE);
    assign busy       = (state_q == S_EMIT);
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign zero_err   = zero_err_q;

endmodule

// File: doc/encoder_8to3_scan.md
# encoder_8to3_scan

Sequential 8-to-3 encoder that turns an 8-bit request vector back into 3-bit indices. It is the inverse companion of the team's 3-to-8 one-hot decoder. It accepts one 8-bit vector per transaction and emits the 3-bit index of every set bit, one index per output handshake, in priority order. It sits between request-collecting logic and any consumer that works on encoded indices. For each transaction, the OR of the one-hot decodes of all emitted indices equals the captured vector.

## Interface
- LSB_FIRST, 1, emission order: 1 = lowest set bit first, 0 = highest set bit first.

- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- din, input, 8, request vector.
- din_valid, input, 1, din is valid this cycle.
- din_ready, output, 1, block can accept a vector; high only in IDLE.
- dout, output, 3, encoded index of the current set bit; 3'd0 when dout_valid=0.
- dout_valid, output, 1, dout holds a valid index.
- dout_ready, input, 1, consumer accepts dout this cycle.
- dout_last, output, 1, current index is the final one of the transaction; qualified by dout_valid.
- busy, output, 1, high in EMIT.
- zero_err, output, 1, one-cycle pulse when a vector of 8'h00 is accepted.

## Operation
- Registered state: 2-state FSM (IDLE, EMIT) plus an 8-bit pending register.
- Reset (rst_n low, asynchronous):
  - state=IDLE, pending=8'h00.
  - dout=0, dout_valid=0, dout_last=0, busy=0, zero_err=0.
  - din_ready=1 (IDLE).
- IDLE:
  - din_ready=1.
  - On din_valid & din_ready with din≠0: pending←din, go to EMIT.
  - On din_valid & din_ready with din=0: zero_err=1 next cycle for exactly one cycle, stay in IDLE, no dout_valid.
- EMIT:
  - din_ready=0, busy=1, dout_valid=1.
  - dout = index of the selected bit in pending: lowest set bit if LSB_FIRST=1, highest if 0.
  - dout_last=1 when pending has exactly one set bit.
  - On dout_valid & dout_ready: clear the selected bit in pending.
  - If dout_last was 1 on that handshake, go to IDLE.
- dout, dout_valid, dout_last and busy are decoded from registered state only; there is no combinational path from din, din_valid or dout_ready to any output.
- din is ignored when din_ready=0; no queuing.
- Index arithmetic: bit position k maps to dout=k[2:0]. Range 0..7; no wrap.

## Timing
- Vector accepted at edge N: dout_valid=1 and first index on dout from cycle N+1.
- With dout_ready held high, a vector with k set bits produces k consecutive beats in cycles N+1..N+k.
- Last handshake at edge M: din_ready=1 and dout_valid=0 from cycle M+1.
- Throughput: one new vector at most every k+1 cycles.
- Backpressure (dout_ready=0): dout, dout_valid and dout_last stay stable; pending is unchanged.
- Zero-vector accept at edge N: zero_err=1 during cycle N+1 only; din_ready stays 1, so back-to-back vectors are accepted.
- Reset asserted mid-EMIT: all outputs return to reset values immediately. Pending indices are discarded and nothing is emitted after release.
- din_valid held high in EMIT: has no effect; the vector is accepted only after return to IDLE.

## Test plan
- Reset: rst_n low → din_ready=1, dout_valid=0, dout=0, busy=0, zero_err=0. After release, stable with no input.
- Single bit: LSB_FIRST=1, din=8'b0010_0000 accepted, dout_ready=1 → one beat dout=3'd5, dout_last=1. din_ready=1 on the following cycle.
- Multi bit, both orders (dout_ready=1):
  - LSB_FIRST=1, din=8'b1000_0101 → beats 0, 2, 7 in three consecutive cycles, dout_last only on 7.
  - LSB_FIRST=0, same din → beats 7, 2, 0, dout_last only on 0.
- Backpressure: din=8'hFF, dout_ready toggled 1,0,0,1,… → dout holds during 0-cycles. All indices 0..7 appear exactly once, in order. dout_last on index 7.
- Zero vector: din=8'h00 with din_valid=1 → zero_err pulse for one cycle, no dout_valid. Immediate next vector 8'h01 accepted, giving dout=0 with dout_last=1.
- Reset mid-operation: din=8'hF0, rst_n pulsed low after the first beat (dout=4) → outputs at reset values asynchronously. After release, no further beats; din_ready=1.
